// File: rtl/mreq_responder_if.sv
// rtl/mreq_responder_if.sv - memory-request bus signals between initiator and responder
interface mreq_responder_if #(
   parameter int AW = 24
);
   logic          mreq;
   logic          rw;
   logic [2:0]    w;
   logic          justify;
   logic [AW-1:0] a;
   logic [63:0]   din;
   logic [63:0]   dout;
   logic          ack;
   logic          notack;

   modport master (
      output mreq, rw, w, justify, a, din,
      input  dout, ack, notack
   );

   modport slave (
      input  mreq, rw, w, justify, a, din,
      output dout, ack, notack
   );
endinterface

// File: rtl/mreq_responder.sv
// rtl/mreq_responder.sv - memory-request bus responder driving a single-port local memory
// Optional feature macro MREQ_JUSTIFY_EN: right-justify narrow read data when justify is latched high.
module mreq_responder #(
   parameter int AW          = 24,
   parameter int WAIT_STATES = 1
) (
   input  logic            sys_clk,
   input  logic            reset,
   mreq_responder_if.slave bus,
   output logic [AW-4:0]   mem_addr,
   output logic [7:0]      mem_be,
   output logic            mem_re,
   output logic            mem_we,
   output logic [63:0]     mem_wdata,
   input  logic [63:0]     mem_rdata,
   input  logic            mem_rdy
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          rw_q, rw_d;
   logic          ack_q, ack_d;
   logic          notack_q, notack_d;
   logic          mem_re_q, mem_re_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-4:0] mem_addr_q, mem_addr_d;
   logic [7:0]    mem_be_q, mem_be_d;
   logic [63:0]   mem_wdata_q, mem_wdata_d;
   logic [63:0]   dout_q, dout_d;
   logic [63:0]   rdata_sel;

   // Lane mask with lane 0 in bit 7; the low address bits are truncated to the transfer size.
   function automatic logic [7:0] lane_mask(input logic [2:0] w, input logic [2:0] lo);
      logic [7:0] m;
      case (w)
         3'b001:  m = 8'h80 >> lo;
         3'b010:  m = 8'hC0 >> {lo[2:1], 1'b0};
         3'b100:  m = 8'hF0 >> {lo[2], 2'b00};
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

`ifdef MREQ_JUSTIFY_EN
   logic [2:0] w_q, w_d;
   logic [2:0] lo_q, lo_d;
   logic       justify_q, justify_d;

   // Shift the selected lanes to the top of the phrase, then take them as the low bits.
   function automatic logic [63:0] justify_lanes(input logic [63:0] data, input logic [2:0] w,
                                                 input logic [2:0] lo);
      logic [63:0] sh;
      logic [63:0] r;
      sh = data;
      case (w)
         3'b001: begin
            sh = data << {lo, 3'b000};
            r  = {56'd0, sh[63:56]};
         end
         3'b010: begin
            sh = data << {lo[2:1], 4'b0000};
            r  = {48'd0, sh[63:48]};
         end
         3'b100: begin
            sh = data << {lo[2], 5'b00000};
            r  = {32'd0, sh[63:32]};
         end
         default: r = sh;
      endcase
      return r;
   endfunction

   // Read data as it will be presented on dout: justified only when requested.
   always_comb begin
      rdata_sel = mem_rdata;
      if (justify_q) rdata_sel = justify_lanes(mem_rdata, w_q, lo_q);
   end
`else
   logic unused_justify;
   assign unused_justify = bus.justify;
   assign rdata_sel      = mem_rdata;
`endif

   // Next-state and registered-output computation for the request cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rw_d        = rw_q;
      ack_d       = 1'b0;
      mem_re_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      dout_d      = dout_q;
`ifdef MREQ_JUSTIFY_EN
      w_d         = w_q;
      lo_d        = lo_q;
      justify_d   = justify_q;
`endif
      case (state_q)
         S_IDLE: begin
            // A still-high mreq during ack belongs to the finished cycle.
            if (bus.mreq && !ack_q) begin
               rw_d        = bus.rw;
               mem_addr_d  = bus.a[AW-1:3];
               mem_be_d    = lane_mask(bus.w, bus.a[2:0]);
               mem_wdata_d = bus.din;
               cnt_d       = 4'(WAIT_STATES);
               mem_re_d    = bus.rw;
               mem_we_d    = !bus.rw;
`ifdef MREQ_JUSTIFY_EN
               w_d         = bus.w;
               lo_d        = bus.a[2:0];
               justify_d   = bus.justify;
`endif
               state_d     = S_ACCESS;
            end
         end
         // The strobe cycle already counts as the first wait evaluation.
         S_ACCESS, S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d   = cnt_q - 4'd1;
               state_d = S_WAIT;
            end else if (mem_rdy) begin
               if (rw_q) dout_d = rdata_sel;
               ack_d   = 1'b1;
               state_d = S_ACK;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      notack_d = !ack_d;
   end

   // State and output registers; reset abandons any cycle in progress.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         rw_q        <= 1'b0;
         ack_q       <= 1'b0;
         notack_q    <= 1'b1;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= 8'h00;
         mem_wdata_q <= 64'd0;
         dout_q      <= 64'd0;
`ifdef MREQ_JUSTIFY_EN
         w_q         <= 3'd0;
         lo_q        <= 3'd0;
         justify_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rw_q        <= rw_d;
         ack_q       <= ack_d;
         notack_q    <= notack_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         dout_q      <= dout_d;
`ifdef MREQ_JUSTIFY_EN
         w_q         <= w_d;
         lo_q        <= lo_d;
         justify_q   <= justify_d;
`endif
      end
   end

   assign bus.ack    = ack_q;
   assign bus.notack = notack_q;
   assign bus.dout   = dout_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_re     = mem_re_q;
   assign mem_we     = mem_we_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/mreq_responder.md
Name: mreq_responder

Overview:
Target-side (responder) end of the internal memory-request bus: the slave that answers the mreq/rw/w/justify cycles issued by the CPU bus-master interface.
- Samples a held mreq, decodes width and address into byte-lane enables, and drives a single-port local memory/register bank.
- Applies configurable wait states, then returns a one-cycle ack (with notack as its complement) and read data.
- Sits in Tom between the bus arbiter and any local RAM or register file that answers bus cycles.

Parameters:
AW, 24, address width in bits.
WAIT_STATES, 1, extra cycles inserted before ack; range 0-15; 4-bit counter.

Ports:
sys_clk  in  1  system clock; all state changes on rising edge.
reset  in  1  synchronous reset, active-high.
mreq  in  1  request; initiator holds it high until it samples ack.
rw  in  1  1 = read, 0 = write; sampled with mreq.
w  in  3  width code: 001 = byte, 010 = 16-bit, 100 = 32-bit; any other value = 64-bit phrase.
justify  in  1  read-data justification request; used only with the optional feature.
a  in  AW  byte address; sampled with mreq.
din  in  64  write data, big-endian lanes (lane 0 = bits 63:56); sampled with mreq.
dout  out  64  read data; valid while ack = 1.
ack  out  1  one-cycle acknowledge.
notack  out  1  complement of ack.
mem_addr  out  AW-3  phrase address to local memory.
mem_be  out  8  byte-lane enables; bit 7 = lane 0 (bits 63:56).
mem_re  out  1  one-cycle read strobe.
mem_we  out  1  one-cycle write strobe.
mem_wdata  out  64  write data to local memory.
mem_rdata  in  64  read data from local memory.
mem_rdy  in  1  local memory ready; low stretches the wait state.

Behaviour:
- Reset: state = IDLE; ack = 0, notack = 1, mem_re = mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0, dout = 0, wait counter = 0.
- Reset mid-cycle: the cycle is abandoned; no ack, no further strobes. Reset has priority over every other event.
- All outputs are registered.
- States: IDLE, ACCESS, WAIT, ACK.
- IDLE:
  - On a rising edge with mreq = 1 and ack = 0: latch rw, w, a and din; compute mem_be and mem_addr = a[AW-1:3]; load counter with WAIT_STATES; go to ACCESS.
  - mreq = 1 while ack = 1 is ignored. This guards the cycle in which the initiator has not yet dropped mreq.
- ACCESS: exactly one cycle; mem_re = rw or mem_we = ~rw. Go to WAIT.
- WAIT:
  - Counter non-zero: decrement it.
  - Counter = 0 and mem_rdy = 1: capture mem_rdata into the read holding register (reads only), go to ACK.
  - Counter = 0 and mem_rdy = 0: stay in WAIT indefinitely.
- ACK: ack = 1, notack = 0 for exactly one cycle, then IDLE.
  - Reads: dout = captured data.
  - Writes: dout holds its previous value.
- Latency: mreq first sampled high at edge 0 → ACCESS during cycle 1 → ack during cycle 2 + WAIT_STATES + (cycles with mem_rdy low after the counter reaches 0). Minimum 2 cycles.
- Back-to-back: a new request can be accepted at the edge that ends the IDLE cycle following ack. Throughput is at best one transfer per 3 + WAIT_STATES cycles.
- mreq dropped before ack (protocol violation): the cycle still completes and ack is issued.
- Byte enables (low address bits ignored beyond alignment; unaligned requests are force-aligned):
  - byte: a single lane a[2:0].
  - 16-bit: lanes {2*a[2:1], 2*a[2:1]+1}.
  - 32-bit: lanes 4*a[2] through 4*a[2]+3.
  - phrase: all eight lanes (mem_be = 8'hFF).
- mem_wdata = latched din unmodified. The initiator places data on the correct lanes.

Optional Feature:
- Macro: MREQ_JUSTIFY_EN.
- Defined: on reads with latched justify = 1, dout is the selected lanes right-justified to bits [n-1:0] and zero-filled above:
  - byte: dout = {56'b0, lane}.
  - 16-bit: dout = {48'b0, lanes}.
  - 32-bit: dout = {32'b0, lanes}.
  - phrase: unchanged.
- Not defined: the justify input is ignored (unused); dout always equals the raw phrase.
- Writes are unaffected in both builds.

Test Plan:
- Reset during WAIT: reset pulse → next cycle ack = 0, notack = 1, no mem_re/mem_we, state IDLE; following mreq is serviced normally.
- Phrase write, WAIT_STATES = 0, mem_rdy = 1: mreq = 1, rw = 0, w = 000, a = 0x000010, din = 0x0123456789ABCDEF → mem_we in cycle 1 with mem_addr = 0x2, mem_be = 0xFF, mem_wdata = din; ack in cycle 2 only.
- Byte read, WAIT_STATES = 3, mem_rdata = 0x1122334455667788:
  - mreq with w = 001, a = 0x000005 → mem_be = 0x04, mem_re in cycle 1, ack in cycle 5, dout = 0x1122334455667788.
  - With MREQ_JUSTIFY_EN and justify = 1 → dout = 0x0000000000000066.
- mem_rdy stall: 32-bit read, a = 0x4, WAIT_STATES = 0, mem_rdy low for 4 cycles → mem_be = 0x0F, ack delayed by exactly 4 cycles, single ack pulse.
- Held mreq: initiator keeps mreq = 1 through the ack cycle and drops it one cycle later → exactly one memory strobe and one ack per request; a second request issued two cycles after ack is accepted.
- 16-bit write, a = 0x6 → mem_be = 0x03; a = 0x7 (unaligned) → mem_be = 0x03 (force-aligned).
